vga_mem_arbiter: RTL
====================

VGA_MEM_ARBITER -- requirements
Module: vga_mem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 19, pixel memory address width (800x600 SVGA).
REQ-002 SHALL have parameter DW, default 3, pixel data width (R,G,B bits as driven to vga_module).
REQ-003 SHALL have parameter WR_TIMEOUT, default 1023, writer starvation limit in clk cycles.
REQ-004 SHALL have ports:
 clk  in  1  40 MHz pixel clock (PLL output); all logic on rising edge.
 rst  in  1  synchronous, active-high reset.
 blank  in  1  high during horizontal or vertical blanking, from timing generator.
 disp_req  in  1  display fetch request; held until disp_ack.
 disp_addr  in  AW  display fetch address.
 disp_ack  out  1  display access issued this cycle.
 disp_rdata  out  DW  fetched pixel.
 disp_rvalid  out  1  disp_rdata valid, one-cycle pulse per fetch.
 wr_req  in  1  writer request; held until wr_ack.
 wr_addr  in  AW  write address.
 wr_data  in  DW  write data.
 wr_ack  out  1  write issued this cycle.
 mem_en  out  1  single-port memory enable.
 mem_we  out  1  memory write enable.
 mem_addr  out  AW  memory address.
 mem_wdata  out  DW  memory write data.
 mem_rdata  in  DW  memory read data, valid the cycle after mem_en with mem_we=0.
 force_cnt  out  8  saturating count of forced writer slots.

Function
REQ-005 SHALL complete a transfer in any cycle where req and ack are both high; at most one of disp_ack, wr_ack SHALL be high per cycle.
REQ-006 SHALL derive disp_ack, wr_ack and mem_* combinationally from requests, blank, and registered state; no request-to-ack register delay.
REQ-007 SHALL on disp_ack drive mem_en=1, mem_we=0, mem_addr=disp_addr; on wr_ack drive mem_en=1, mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data; otherwise mem_en=0, mem_we=0, mem_addr and mem_wdata=0.
REQ-008 SHALL, blank=0 (active video), grant display with fixed priority over writer, except under REQ-011.
REQ-009 SHALL, blank=1, arbitrate round-robin using a 1-bit pointer rr (0=display next, 1=writer next); with both requesting, grant per rr; with one requesting, grant it.
REQ-010 SHALL set rr to the opposite of the requester granted in every granted cycle, in both active and blank.
REQ-011 SHALL keep a writer wait counter wr_wait: +1 each cycle wr_req=1 and wr_ack=0; cleared on wr_ack or wr_req=0; when wr_wait=WR_TIMEOUT and blank=0, grant writer over display that cycle (forced slot).
REQ-012 SHALL saturate wr_wait at WR_TIMEOUT.
REQ-013 SHALL increment force_cnt on each forced slot, saturating at 255; it SHALL not wrap.
REQ-014 SHALL pipeline display reads: disp_ack at cycle T -> mem_rdata at T+1 -> disp_rdata registered and disp_rvalid=1 during T+2; back-to-back acks SHALL yield back-to-back rvalid pulses in order.
REQ-015 SHALL hold disp_rdata between rvalid pulses.
REQ-016 SHALL sample blank in the same cycle as the arbitration decision; a blank edge SHALL take effect immediately on that cycle.
REQ-017 SHALL not cancel in-flight reads when blank changes or a forced slot occurs.

Reset
REQ-018 SHALL, while rst=1, drive disp_ack=0, wr_ack=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-019 SHALL on rst clear rr=0, wr_wait=0, force_cnt=0, disp_rvalid=0, disp_rdata=0, and discard in-flight reads (no rvalid after reset release for pre-reset acks).
REQ-020 SHALL resume arbitration the first cycle after rst deasserts.

Verification
REQ-021 blank=0, disp_req=1 addr 0x00010, wr_req=1, rst released -> disp_ack every cycle, wr_ack=0; mem_rdata 5 at T+1 -> disp_rdata=5, disp_rvalid=1 at T+2.
REQ-022 blank=1, both requesting continuously from rr=0 -> grants alternate D,W,D,W; mem_we pattern 0,1,0,1.
REQ-023 blank=0, disp_req and wr_req held, WR_TIMEOUT=4 -> wr_ack in 5th cycle, disp_ack low that cycle, force_cnt 0->1, wr_wait cleared.
REQ-024 force_cnt preloaded by 260 forced slots -> force_cnt=255, stays 255.
REQ-025 disp_ack at T, rst=1 at T+1 -> disp_rvalid=0 at T+2 and after; all outputs at reset values.
REQ-026 blank 1->0 with rr=1 and both requesting -> display granted in first active cycle.

Source files
------------

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: shares one single-port pixel memory between the VGA
// display fetch path and a writer. Display wins during active video,
// blanking uses round-robin, and a starved writer gets a forced slot.
// Ports:
//   clk, rst               : pixel clock, synchronous active-high reset
//   blank                  : blanking indicator from the timing generator
//   disp_req/addr/ack      : display fetch request handshake
//   disp_rdata/rvalid      : fetched pixel, two cycles after disp_ack
//   wr_req/addr/data/ack   : writer request handshake
//   mem_en/we/addr/wdata   : single-port memory command
//   mem_rdata              : memory read data, one cycle after a read
//   force_cnt              : saturating count of forced writer slots
module vga_mem_arbiter #(
    parameter int AW         = 19,
    parameter int DW         = 3,
    parameter int WR_TIMEOUT = 1023
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          blank,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ack,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_rvalid,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    force_cnt
);

    localparam int WW = (WR_TIMEOUT < 2) ? 1 : $clog2(WR_TIMEOUT + 1);
    localparam logic [WW-1:0] TMO = WW'(WR_TIMEOUT);

    logic          rr;
    logic [WW-1:0] wr_wait;
    logic          rd_pend;
    logic          forced;

    // Grant decision is purely combinational on requests, blank and state
    always_comb begin
        disp_ack = 1'b0;
        wr_ack   = 1'b0;
        forced   = 1'b0;
        if (!rst) begin
            if (!blank) begin
                if (wr_req && wr_wait == TMO) begin
                    wr_ack = 1'b1;
                    forced = 1'b1;
                end else if (disp_req) begin
                    disp_ack = 1'b1;
                end else if (wr_req) begin
                    wr_ack = 1'b1;
                end
            end else begin
                if (disp_req && wr_req) begin
                    if (rr) wr_ack = 1'b1;
                    else    disp_ack = 1'b1;
                end else if (disp_req) begin
                    disp_ack = 1'b1;
                end else if (wr_req) begin
                    wr_ack = 1'b1;
                end
            end
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_ack) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (wr_ack) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = wr_addr;
            mem_wdata = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr        <= 1'b0;
            wr_wait   <= '0;
            force_cnt <= '0;
        end else begin
            // Pointer always favours the requester not served this cycle
            if (disp_ack)    rr <= 1'b1;
            else if (wr_ack) rr <= 1'b0;

            if (wr_ack || !wr_req) wr_wait <= '0;
            else if (wr_wait != TMO) wr_wait <= wr_wait + 1'b1;

            if (forced && force_cnt != 8'hFF)
                force_cnt <= force_cnt + 8'd1;
        end
    end

    // Read pipeline: ack at T, memory data at T+1, registered at T+2.
    // Reset flushes the pending stage so pre-reset acks never return.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_pend     <= 1'b0;
            disp_rvalid <= 1'b0;
            disp_rdata  <= '0;
        end else begin
            rd_pend     <= disp_ack;
            disp_rvalid <= rd_pend;
            if (rd_pend) disp_rdata <= mem_rdata;
        end
    end

endmodule
